// File: rtl/ldr_ioctl_bridge_if.sv
// Bus bundle between hps_io's ioctl download stream, the bridge, and the
// Zet98MiSTer loader port. The master modport is the bridge side; the slave
// modport is the surrounding environment (hps_io + loader).
// Optional checksum signal is present only when LDR_CSUM_EN is defined.
interface ldr_ioctl_bridge_if #(
  parameter int unsigned AW = 20
);
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wait;
  logic [AW-1:0] LDR_ADDR;
  logic [7:0]    LDR_WDAT;
  logic          LDR_OE;
  logic          LDR_WR;
  logic          LDR_ACK;
  logic          LDR_DONE;
  logic [20:0]   ldr_bytes;
  logic          ldr_err;
`ifdef LDR_CSUM_EN
  logic [15:0]   ldr_csum;

  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, LDR_ACK,
    output ioctl_wait, LDR_ADDR, LDR_WDAT, LDR_OE, LDR_WR, LDR_DONE, ldr_bytes, ldr_err,
    output ldr_csum
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, LDR_ACK,
    input  ioctl_wait, LDR_ADDR, LDR_WDAT, LDR_OE, LDR_WR, LDR_DONE, ldr_bytes, ldr_err,
    input  ldr_csum
  );
`else
  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, LDR_ACK,
    output ioctl_wait, LDR_ADDR, LDR_WDAT, LDR_OE, LDR_WR, LDR_DONE, ldr_bytes, ldr_err
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, LDR_ACK,
    input  ioctl_wait, LDR_ADDR, LDR_WDAT, LDR_OE, LDR_WR, LDR_DONE, ldr_bytes, ldr_err
  );
`endif
endinterface

// File: rtl/ldr_ioctl_bridge.sv
// Buffered bridge from the hps_io ioctl download stream to the Zet98MiSTer
// loader port. Bytes are queued in a small FIFO, written to the loader with a
// level WR / rising-edge ACK handshake, and hps_io is throttled via ioctl_wait.
// Define LDR_CSUM_EN to add the ldr_csum running byte checksum.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a download of LDR_INDEX to start
// LOAD  | download active; accepting bytes and writing to loader
// DRAIN | download ended; flushing the remaining queued bytes
// DONE  | load finished; terminal until reset, new downloads ignored
module ldr_ioctl_bridge #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  LDR_INDEX = 8'd0,
  parameter int unsigned AW        = 20   // must be < 25
) (
  input  logic               clk_sys,
  input  logic               rstn,
  ldr_ioctl_bridge_if.master bus
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned EW = AW + 8;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          dl_q, dl_d;
  logic          ack_q, ack_d;
  logic          oe_q, oe_d;
  logic          wr_q, wr_d;
  logic          wait_q, wait_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [20:0]   bytes_q, bytes_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
`ifdef LDR_CSUM_EN
  logic [15:0]   csum_q, csum_d;
`endif

  logic          dl_rise, dl_fall;
  logic          empty, full;
  logic          addr_ok, strobe_load, push, drop, complete;
  logic [PW-1:0] count, count_nxt;
  logic [EW-1:0] head;

  // Decode of download edges, FIFO status and the push/pop events of this cycle.
  always_comb begin
    dl_rise     = bus.ioctl_download & ~dl_q;
    dl_fall     = ~bus.ioctl_download & dl_q;
    count       = wp_q - rp_q;
    empty       = (wp_q == rp_q);
    full        = (wp_q[PW-1] != rp_q[PW-1]) && (wp_q[IW-1:0] == rp_q[IW-1:0]);
    addr_ok     = ~|bus.ioctl_addr[24:AW];
    strobe_load = (state_q == S_LOAD) && bus.ioctl_wr;
    push        = strobe_load && addr_ok && !full;
    drop        = strobe_load && (!addr_ok || full);
    complete    = bus.LDR_ACK && !ack_q && wr_q;
    count_nxt   = count + PW'(push) - PW'(complete);
    head        = mem_q[rp_q[IW-1:0]];
  end

  // State register.
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a push in the falling-edge cycle is still taken in LOAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (dl_rise && (bus.ioctl_index == LDR_INDEX)) state_d = S_LOAD;
      S_LOAD:  if (dl_fall) state_d = S_DRAIN;
      S_DRAIN: if (empty && !wr_q) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values: FIFO, handshake, throttle, status.
  always_comb begin
    dl_d    = bus.ioctl_download;
    ack_d   = bus.LDR_ACK;
    oe_d    = (state_d == S_LOAD) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);
    // Threshold DEPTH-1 leaves one slot for a strobe already in flight.
    wait_d  = (state_d == S_LOAD) && (count_nxt >= PW'(DEPTH - 1));
    err_d   = err_q | drop;
    wp_d    = wp_q + PW'(push);
    rp_d    = rp_q + PW'(complete);
    mem_d   = mem_q;
    if (push) mem_d[wp_q[IW-1:0]] = {bus.ioctl_addr[AW-1:0], bus.ioctl_dout};
    wr_d    = wr_q;
    if (complete)                    wr_d = 1'b0;
    else if (!wr_q && !empty && oe_q) wr_d = 1'b1;
    bytes_d = bytes_q;
    if (complete && (bytes_q != {21{1'b1}})) bytes_d = bytes_q + 21'd1;
`ifdef LDR_CSUM_EN
    csum_d  = csum_q;
    if (complete) csum_d = csum_q + {8'h00, head[7:0]};
`endif
  end

  // Datapath registers; reset flushes the FIFO and drops LDR_WR immediately.
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      dl_q    <= 1'b0;
      ack_q   <= 1'b0;
      oe_q    <= 1'b0;
      wr_q    <= 1'b0;
      wait_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bytes_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      mem_q   <= '{default: '0};
`ifdef LDR_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      dl_q    <= dl_d;
      ack_q   <= ack_d;
      oe_q    <= oe_d;
      wr_q    <= wr_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bytes_q <= bytes_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      mem_q   <= mem_d;
`ifdef LDR_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.LDR_ADDR   = head[EW-1:8];
  assign bus.LDR_WDAT   = head[7:0];
  assign bus.LDR_OE     = oe_q;
  assign bus.LDR_WR     = wr_q;
  assign bus.LDR_DONE   = done_q;
  assign bus.ldr_bytes  = bytes_q;
  assign bus.ldr_err    = err_q;
`ifdef LDR_CSUM_EN
  assign bus.ldr_csum   = csum_q;
`endif

endmodule

// File: tb/tb_ldr_ioctl_bridge.sv
// Directed bench for ldr_ioctl_bridge: a cycle table for a basic load, then
// hand-written sequences for wrong index, backpressure, out-of-range address,
// ack level/edge behaviour and reset in the middle of a load.
module tb_ldr_ioctl_bridge;

  logic clk_sys = 1'b0;
  logic rstn    = 1'b0;
  always #5 clk_sys = ~clk_sys;

  ldr_ioctl_bridge_if #(.AW(20)) bus ();

  ldr_ioctl_bridge #(.DEPTH(4), .LDR_INDEX(8'd0), .AW(20)) dut (
    .clk_sys (clk_sys),
    .rstn    (rstn),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        dl;
    logic [7:0]  idx;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        ack;
    logic        e_wait;
    logic        e_oe;
    logic        e_wr;
    logic [19:0] e_addr;
    logic [7:0]  e_wdat;
    logic [20:0] e_bytes;
    logic        e_err;
    logic        e_done;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(logic dl, logic [7:0] idx, logic wr, logic [24:0] addr,
                              logic [7:0] dout, logic ack, logic e_wait, logic e_oe,
                              logic e_wr, logic [19:0] e_addr, logic [7:0] e_wdat,
                              logic [20:0] e_bytes, logic e_err, logic e_done);
    vec_t v;
    v.dl = dl; v.idx = idx; v.wr = wr; v.addr = addr; v.dout = dout; v.ack = ack;
    v.e_wait = e_wait; v.e_oe = e_oe; v.e_wr = e_wr; v.e_addr = e_addr;
    v.e_wdat = e_wdat; v.e_bytes = e_bytes; v.e_err = e_err; v.e_done = e_done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.LDR_ACK        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic wait_wr(input string name);
    int n = 0;
    while (bus.LDR_WR !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({name, " wr_seen"}, 32'(bus.LDR_WR), 32'd1);
  endtask

  task automatic ack_write(input string name, input logic [19:0] ea, input logic [7:0] ed);
    wait_wr(name);
    chk({name, " addr"}, 32'(bus.LDR_ADDR), 32'(ea));
    chk({name, " data"}, 32'(bus.LDR_WDAT), 32'(ed));
    bus.LDR_ACK = 1'b1;
    tick();
    bus.LDR_ACK = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (bus.LDR_DONE !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({name, " done"}, 32'(bus.LDR_DONE), 32'd1);
    chk({name, " oe"}, 32'(bus.LDR_OE), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic load, cycle by cycle. Inputs apply to the next edge; expected
    // values are the outputs just after that edge.
    //             dl    idx    wr    addr   dout   ack   wait  oe    wr    eaddr  edat   bytes err   done
    vecs[0]  = mk(1'b1, 8'd0, 1'b0, 25'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 20'd0, 8'h00, 21'd0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 8'd0, 1'b1, 25'd0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 20'd0, 8'h00, 21'd0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 8'd0, 1'b1, 25'd1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 20'd0, 8'h11, 21'd0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 8'd0, 1'b1, 25'd2, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 20'd0, 8'h11, 21'd0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 8'd0, 1'b0, 25'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 20'd0, 8'h11, 21'd0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 8'd0, 1'b0, 25'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 20'd0, 8'h00, 21'd1, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 8'd0, 1'b0, 25'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 20'd1, 8'h22, 21'd1, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 8'd0, 1'b0, 25'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 20'd1, 8'h22, 21'd1, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 8'd0, 1'b0, 25'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 20'd0, 8'h00, 21'd2, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 8'd0, 1'b0, 25'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 20'd2, 8'h33, 21'd2, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 8'd0, 1'b0, 25'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 20'd2, 8'h33, 21'd2, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 8'd0, 1'b0, 25'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 20'd2, 8'h33, 21'd2, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 8'd0, 1'b0, 25'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 20'd0, 8'h00, 21'd3, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 8'd0, 1'b0, 25'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0, 8'h00, 21'd3, 1'b0, 1'b1);
    vecs[14] = mk(1'b1, 8'd0, 1'b0, 25'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0, 8'h00, 21'd3, 1'b0, 1'b1);
    vecs[15] = mk(1'b1, 8'd0, 1'b1, 25'd5, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0, 8'h00, 21'd3, 1'b0, 1'b1);

    do_reset();
    chk("reset oe",    32'(bus.LDR_OE),     32'd0);
    chk("reset wr",    32'(bus.LDR_WR),     32'd0);
    chk("reset wait",  32'(bus.ioctl_wait), 32'd0);
    chk("reset done",  32'(bus.LDR_DONE),   32'd0);
    chk("reset bytes", 32'(bus.ldr_bytes),  32'd0);
    chk("reset err",   32'(bus.ldr_err),    32'd0);
`ifdef LDR_CSUM_EN
    chk("reset csum",  32'(bus.ldr_csum),   32'd0);
`endif

    for (int i = 0; i < 16; i++) begin
      bus.ioctl_download = vecs[i].dl;
      bus.ioctl_index    = vecs[i].idx;
      bus.ioctl_wr       = vecs[i].wr;
      bus.ioctl_addr     = vecs[i].addr;
      bus.ioctl_dout     = vecs[i].dout;
      bus.LDR_ACK        = vecs[i].ack;
      tick();
      chk($sformatf("vec%0d wait", i),  32'(bus.ioctl_wait), 32'(vecs[i].e_wait));
      chk($sformatf("vec%0d oe", i),    32'(bus.LDR_OE),     32'(vecs[i].e_oe));
      chk($sformatf("vec%0d wr", i),    32'(bus.LDR_WR),     32'(vecs[i].e_wr));
      chk($sformatf("vec%0d bytes", i), 32'(bus.ldr_bytes),  32'(vecs[i].e_bytes));
      chk($sformatf("vec%0d err", i),   32'(bus.ldr_err),    32'(vecs[i].e_err));
      chk($sformatf("vec%0d done", i),  32'(bus.LDR_DONE),   32'(vecs[i].e_done));
      if (vecs[i].e_wr) begin
        chk($sformatf("vec%0d addr", i), 32'(bus.LDR_ADDR), 32'(vecs[i].e_addr));
        chk($sformatf("vec%0d wdat", i), 32'(bus.LDR_WDAT), 32'(vecs[i].e_wdat));
      end
    end
`ifdef LDR_CSUM_EN
    chk("basic csum", 32'(bus.ldr_csum), 32'h0066);
`endif

    // Wrong index: nothing happens, bridge stays in IDLE.
    do_reset();
    bus.ioctl_index    = 8'd1;
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 10; i++) begin
      strobe(25'(i), 8'(i + 1));
      chk($sformatf("widx%0d oe", i),   32'(bus.LDR_OE),     32'd0);
      chk($sformatf("widx%0d wait", i), 32'(bus.ioctl_wait), 32'd0);
      chk($sformatf("widx%0d wr", i),   32'(bus.LDR_WR),     32'd0);
    end
    tick();
    chk("widx bytes", 32'(bus.ldr_bytes), 32'd0);
    chk("widx err",   32'(bus.ldr_err),   32'd0);
    bus.ioctl_download = 1'b0;
    tick();

    // Backpressure, continuing from IDLE left by the wrong-index download.
    bus.ioctl_index    = 8'd0;
    bus.ioctl_download = 1'b1;
    tick();
    chk("bp oe", 32'(bus.LDR_OE), 32'd1);
    strobe(25'd0, 8'hA0);
    chk("bp wait1", 32'(bus.ioctl_wait), 32'd0);
    strobe(25'd1, 8'hA1);
    chk("bp wait2", 32'(bus.ioctl_wait), 32'd0);
    strobe(25'd2, 8'hA2);
    chk("bp wait3", 32'(bus.ioctl_wait), 32'd1);
    chk("bp err3",  32'(bus.ldr_err),    32'd0);
    strobe(25'd3, 8'hA3);
    chk("bp err4",  32'(bus.ldr_err),    32'd0);
    chk("bp wait4", 32'(bus.ioctl_wait), 32'd1);
    strobe(25'd4, 8'hA4);
    chk("bp err5",  32'(bus.ldr_err),    32'd1);
    bus.ioctl_download = 1'b0;
    tick();
    chk("bp wait drain", 32'(bus.ioctl_wait), 32'd0);
    ack_write("bp w0", 20'd0, 8'hA0);
    ack_write("bp w1", 20'd1, 8'hA1);
    ack_write("bp w2", 20'd2, 8'hA2);
    ack_write("bp w3", 20'd3, 8'hA3);
    wait_done("bp");
    chk("bp bytes",      32'(bus.ldr_bytes), 32'd4);
    chk("bp err sticky", 32'(bus.ldr_err),   32'd1);

    // Out-of-range address is dropped; the top in-range address is written.
    do_reset();
    bus.ioctl_download = 1'b1;
    tick();
    strobe(25'h100000, 8'h5A);
    chk("oor err",  32'(bus.ldr_err), 32'd1);
    tick();
    chk("oor no wr", 32'(bus.LDR_WR), 32'd0);
    strobe(25'h0FFFFF, 8'hC3);
    ack_write("oor w", 20'hFFFFF, 8'hC3);
    chk("oor bytes", 32'(bus.ldr_bytes), 32'd1);

    // Ack held high: only an edge completes a write.
    do_reset();
    bus.ioctl_download = 1'b1;
    tick();
    strobe(25'd16, 8'hB1);
    strobe(25'd17, 8'hB2);
    wait_wr("lvl first");
    chk("lvl addr0", 32'(bus.LDR_ADDR), 32'd16);
    bus.LDR_ACK = 1'b1;
    tick();
    chk("lvl bytes1", 32'(bus.ldr_bytes), 32'd1);
    repeat (4) tick();
    chk("lvl held bytes", 32'(bus.ldr_bytes), 32'd1);
    chk("lvl held wr",    32'(bus.LDR_WR),    32'd1);
    chk("lvl addr1",      32'(bus.LDR_ADDR),  32'd17);
    chk("lvl data1",      32'(bus.LDR_WDAT),  32'hB2);
    bus.LDR_ACK = 1'b0;
    tick();
    chk("lvl low bytes", 32'(bus.ldr_bytes), 32'd1);
    bus.LDR_ACK = 1'b1;
    tick();
    chk("lvl edge bytes", 32'(bus.ldr_bytes), 32'd2);
    bus.LDR_ACK = 1'b0;
    tick();

    // Reset mid-load with two bytes queued, then a fresh download.
    strobe(25'd32, 8'hC1);
    strobe(25'd33, 8'hC2);
    wait_wr("rst pre");
    #2;
    rstn = 1'b0;
    bus.ioctl_download = 1'b0;
    #1;
    chk("rst async wr", 32'(bus.LDR_WR),    32'd0);
    chk("rst bytes",    32'(bus.ldr_bytes), 32'd0);
    chk("rst oe",       32'(bus.LDR_OE),    32'd0);
    tick();
    rstn = 1'b1;
    repeat (2) tick();
    chk("rst empty wr", 32'(bus.LDR_WR), 32'd0);
    bus.ioctl_download = 1'b1;
    tick();
    strobe(25'd0, 8'hFF);
    strobe(25'd1, 8'h02);
    bus.ioctl_download = 1'b0;
    ack_write("rst w0", 20'd0, 8'hFF);
    ack_write("rst w1", 20'd1, 8'h02);
    wait_done("rst");
    chk("rst2 bytes", 32'(bus.ldr_bytes), 32'd2);
    chk("rst2 err",   32'(bus.ldr_err),   32'd0);
`ifdef LDR_CSUM_EN
    chk("rst2 csum",  32'(bus.ldr_csum),  32'h0101);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
